// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the instruction and data caches.
// One transaction in flight; all outputs registered.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned LINE_WIDTH = 128
) (
    input  logic                  clk_i,
    input  logic                  rsn_i,
    input  logic                  ic_rqst_i,
    input  logic [ADDR_WIDTH-1:0] ic_addr_i,
    output logic                  ic_data_ready_o,
    output logic [ADDR_WIDTH-1:0] ic_addr_o,
    output logic [LINE_WIDTH-1:0] ic_data_o,
    input  logic                  dc_rqst_i,
    input  logic                  dc_write_i,
    input  logic [ADDR_WIDTH-1:0] dc_addr_i,
    input  logic [LINE_WIDTH-1:0] dc_data_i,
    output logic                  dc_data_ready_o,
    output logic [ADDR_WIDTH-1:0] dc_addr_o,
    output logic [LINE_WIDTH-1:0] dc_data_o,
    output logic                  mem_rqst_o,
    output logic                  mem_write_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [LINE_WIDTH-1:0] mem_data_o,
    input  logic                  mem_data_ready_i,
    input  logic [LINE_WIDTH-1:0] mem_data_i,
    output logic                  arb_busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic OWN_IC = 1'b0;
    localparam logic OWN_DC = 1'b1;

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_q, last_d;
    logic                  busy_q, busy_d;
    logic                  mem_rqst_q, mem_rqst_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_WIDTH-1:0] mem_data_q, mem_data_d;
    logic                  ic_ready_q, ic_ready_d;
    logic [ADDR_WIDTH-1:0] ic_addr_q, ic_addr_d;
    logic [LINE_WIDTH-1:0] ic_data_q, ic_data_d;
    logic                  dc_ready_q, dc_ready_d;
    logic [ADDR_WIDTH-1:0] dc_addr_q, dc_addr_d;
    logic [LINE_WIDTH-1:0] dc_data_q, dc_data_d;
    logic                  grant_ic_c, grant_dc_c;

    // Next-state, grant and capture logic
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        mem_rqst_d  = mem_rqst_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        ic_ready_d  = 1'b0;
        ic_addr_d   = ic_addr_q;
        ic_data_d   = ic_data_q;
        dc_ready_d  = 1'b0;
        dc_addr_d   = dc_addr_q;
        dc_data_d   = dc_data_q;

        // On a tie the requester that did not win last time is served
        grant_ic_c = ic_rqst_i && (!dc_rqst_i || (last_q == OWN_DC));
        grant_dc_c = dc_rqst_i && (!ic_rqst_i || (last_q == OWN_IC));

        unique case (state_q)
            IDLE: begin
                if (grant_ic_c) begin
                    state_d     = BUSY;
                    owner_d     = OWN_IC;
                    last_d      = OWN_IC;
                    mem_rqst_d  = 1'b1;
                    mem_write_d = 1'b0;
                    mem_addr_d  = ic_addr_i;
                    mem_data_d  = '0;
                end else if (grant_dc_c) begin
                    state_d     = BUSY;
                    owner_d     = OWN_DC;
                    last_d      = OWN_DC;
                    mem_rqst_d  = 1'b1;
                    mem_write_d = dc_write_i;
                    mem_addr_d  = dc_addr_i;
                    mem_data_d  = dc_write_i ? dc_data_i : '0;
                end
            end
            BUSY: begin
                if (mem_data_ready_i) begin
                    state_d     = RESP;
                    mem_rqst_d  = 1'b0;
                    mem_write_d = 1'b0;
                    mem_addr_d  = '0;
                    mem_data_d  = '0;
                    if (owner_q == OWN_IC) begin
                        ic_ready_d = 1'b1;
                        ic_addr_d  = mem_addr_q;
                        ic_data_d  = mem_data_i;
                    end else begin
                        dc_ready_d = 1'b1;
                        dc_addr_d  = mem_addr_q;
                        dc_data_d  = mem_data_i;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IC;
            last_q      <= OWN_DC;
            busy_q      <= 1'b0;
            mem_rqst_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            ic_ready_q  <= 1'b0;
            ic_addr_q   <= '0;
            ic_data_q   <= '0;
            dc_ready_q  <= 1'b0;
            dc_addr_q   <= '0;
            dc_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            mem_rqst_q  <= mem_rqst_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            ic_ready_q  <= ic_ready_d;
            ic_addr_q   <= ic_addr_d;
            ic_data_q   <= ic_data_d;
            dc_ready_q  <= dc_ready_d;
            dc_addr_q   <= dc_addr_d;
            dc_data_q   <= dc_data_d;
        end
    end

    assign ic_data_ready_o = ic_ready_q;
    assign ic_addr_o       = ic_addr_q;
    assign ic_data_o       = ic_data_q;
    assign dc_data_ready_o = dc_ready_q;
    assign dc_addr_o       = dc_addr_q;
    assign dc_data_o       = dc_data_q;
    assign mem_rqst_o      = mem_rqst_q;
    assign mem_write_o     = mem_write_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_data_o      = mem_data_q;
    assign arb_busy_o      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_mem_arbiter;

    localparam int unsigned AW = 20;
    localparam int unsigned LW = 128;

    logic          clk_i = 1'b0;
    logic          rsn_i;
    logic          ic_rqst_i;
    logic [AW-1:0] ic_addr_i;
    logic          ic_data_ready_o;
    logic [AW-1:0] ic_addr_o;
    logic [LW-1:0] ic_data_o;
    logic          dc_rqst_i;
    logic          dc_write_i;
    logic [AW-1:0] dc_addr_i;
    logic [LW-1:0] dc_data_i;
    logic          dc_data_ready_o;
    logic [AW-1:0] dc_addr_o;
    logic [LW-1:0] dc_data_o;
    logic          mem_rqst_o;
    logic          mem_write_o;
    logic [AW-1:0] mem_addr_o;
    logic [LW-1:0] mem_data_o;
    logic          mem_data_ready_i;
    logic [LW-1:0] mem_data_i;
    logic          arb_busy_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [LW-1:0] last_ic_data;

    mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk_i(clk_i), .rsn_i(rsn_i),
        .ic_rqst_i(ic_rqst_i), .ic_addr_i(ic_addr_i),
        .ic_data_ready_o(ic_data_ready_o), .ic_addr_o(ic_addr_o), .ic_data_o(ic_data_o),
        .dc_rqst_i(dc_rqst_i), .dc_write_i(dc_write_i), .dc_addr_i(dc_addr_i), .dc_data_i(dc_data_i),
        .dc_data_ready_o(dc_data_ready_o), .dc_addr_o(dc_addr_o), .dc_data_o(dc_data_o),
        .mem_rqst_o(mem_rqst_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_data_ready_i(mem_data_ready_i), .mem_data_i(mem_data_i),
        .arb_busy_o(arb_busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(negedge clk_i);
    endtask

    // Memory model: wait for a request, hold off 'gap' cycles, then strobe ready for one cycle.
    // Returns on the falling edge of the arbiter's response cycle.
    task automatic mem_serve(input int gap, input logic [LW-1:0] d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (mem_rqst_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) begin
            repeat (gap) tick();
            mem_data_ready_i = 1'b1;
            mem_data_i       = d;
            tick();
            mem_data_ready_i = 1'b0;
            mem_data_i       = '0;
        end
    endtask

    task automatic test_reset();
        rsn_i = 1'b0;
        ic_rqst_i = 1'b0; ic_addr_i = '0;
        dc_rqst_i = 1'b0; dc_write_i = 1'b0; dc_addr_i = '0; dc_data_i = '0;
        mem_data_ready_i = 1'b0; mem_data_i = '0;
        tick();
        n_cmp++; if (mem_rqst_o !== 1'b0) begin n_bad++; $display("FAIL reset mem_rqst: got %b want 0", mem_rqst_o); end
        n_cmp++; if (arb_busy_o !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b want 0", arb_busy_o); end
        n_cmp++; if ({ic_data_ready_o, dc_data_ready_o, mem_write_o} !== 3'b000) begin n_bad++; $display("FAIL reset strobes: got %b want 000", {ic_data_ready_o, dc_data_ready_o, mem_write_o}); end
        n_cmp++; if ({mem_addr_o, ic_addr_o, dc_addr_o} !== '0) begin n_bad++; $display("FAIL reset addrs: got %h want 0", {mem_addr_o, ic_addr_o, dc_addr_o}); end
        n_cmp++; if ({mem_data_o, ic_data_o, dc_data_o} !== '0) begin n_bad++; $display("FAIL reset data: got %h want 0", {mem_data_o, ic_data_o, dc_data_o}); end
        rsn_i = 1'b1;
        tick();
    endtask

    task automatic test_ic_alone();
        bit ok;
        logic [LW-1:0] a5 = {16{8'hA5}};
        ic_rqst_i = 1'b1; ic_addr_i = 20'h00040;
        n_cmp++; if (mem_rqst_o !== 1'b0) begin n_bad++; $display("FAIL ic_alone early_rqst: got %b want 0", mem_rqst_o); end
        tick();
        n_cmp++; if (mem_rqst_o !== 1'b1) begin n_bad++; $display("FAIL ic_alone mem_rqst: got %b want 1", mem_rqst_o); end
        n_cmp++; if (mem_addr_o !== 20'h00040) begin n_bad++; $display("FAIL ic_alone mem_addr: got %h want 00040", mem_addr_o); end
        n_cmp++; if ({mem_write_o, mem_data_o} !== '0) begin n_bad++; $display("FAIL ic_alone wr/data: got %h want 0", {mem_write_o, mem_data_o}); end
        n_cmp++; if (arb_busy_o !== 1'b1) begin n_bad++; $display("FAIL ic_alone busy: got %b want 1", arb_busy_o); end
        mem_serve(3, a5, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL ic_alone timeout: got %b want 1", ok); end
        n_cmp++; if (ic_data_ready_o !== 1'b1) begin n_bad++; $display("FAIL ic_alone ready: got %b want 1", ic_data_ready_o); end
        n_cmp++; if (dc_data_ready_o !== 1'b0) begin n_bad++; $display("FAIL ic_alone dc_ready: got %b want 0", dc_data_ready_o); end
        n_cmp++; if (ic_addr_o !== 20'h00040) begin n_bad++; $display("FAIL ic_alone ic_addr: got %h want 00040", ic_addr_o); end
        n_cmp++; if (ic_data_o !== a5) begin n_bad++; $display("FAIL ic_alone ic_data: got %h want %h", ic_data_o, a5); end
        n_cmp++; if (mem_rqst_o !== 1'b0) begin n_bad++; $display("FAIL ic_alone rqst_drop: got %b want 0", mem_rqst_o); end
        ic_rqst_i = 1'b0;
        tick();
        n_cmp++; if (ic_data_ready_o !== 1'b0) begin n_bad++; $display("FAIL ic_alone pulse_len: got %b want 0", ic_data_ready_o); end
        n_cmp++; if (ic_data_o !== a5) begin n_bad++; $display("FAIL ic_alone hold: got %h want %h", ic_data_o, a5); end
        tick();
        n_cmp++; if ({arb_busy_o, mem_rqst_o} !== 2'b00) begin n_bad++; $display("FAIL ic_alone no_regrant: got %b want 00", {arb_busy_o, mem_rqst_o}); end
    endtask

    task automatic test_tie(input bit ic_first);
        bit ok;
        logic [LW-1:0] da = {4{32'h1111_2222}};
        logic [LW-1:0] db = {4{32'h3333_4444}};
        logic [AW-1:0] first_addr  = ic_first ? 20'h00100 : 20'h00200;
        logic [AW-1:0] second_addr = ic_first ? 20'h00200 : 20'h00100;
        ic_rqst_i = 1'b1; ic_addr_i = 20'h00100;
        dc_rqst_i = 1'b1; dc_write_i = 1'b0; dc_addr_i = 20'h00200;
        tick();
        n_cmp++; if (mem_addr_o !== first_addr) begin n_bad++; $display("FAIL tie%0d first_addr: got %h want %h", ic_first, mem_addr_o, first_addr); end
        mem_serve(1, da, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL tie%0d timeout1: got %b want 1", ic_first, ok); end
        if (ic_first) begin
            n_cmp++; if ({ic_data_ready_o, dc_data_ready_o} !== 2'b10) begin n_bad++; $display("FAIL tie1 ready1: got %b want 10", {ic_data_ready_o, dc_data_ready_o}); end
            n_cmp++; if (ic_data_o !== da) begin n_bad++; $display("FAIL tie1 ic_data: got %h want %h", ic_data_o, da); end
            ic_rqst_i = 1'b0;
        end else begin
            n_cmp++; if ({ic_data_ready_o, dc_data_ready_o} !== 2'b01) begin n_bad++; $display("FAIL tie0 ready1: got %b want 01", {ic_data_ready_o, dc_data_ready_o}); end
            n_cmp++; if (dc_data_o !== da) begin n_bad++; $display("FAIL tie0 dc_data: got %h want %h", dc_data_o, da); end
            dc_rqst_i = 1'b0;
        end
        tick();
        n_cmp++; if ({arb_busy_o, ic_data_ready_o, dc_data_ready_o} !== 3'b000) begin n_bad++; $display("FAIL tie%0d gap: got %b want 000", ic_first, {arb_busy_o, ic_data_ready_o, dc_data_ready_o}); end
        tick();
        n_cmp++; if (mem_addr_o !== second_addr) begin n_bad++; $display("FAIL tie%0d second_addr: got %h want %h", ic_first, mem_addr_o, second_addr); end
        mem_serve(0, db, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL tie%0d timeout2: got %b want 1", ic_first, ok); end
        if (ic_first) begin
            n_cmp++; if ({ic_data_ready_o, dc_data_ready_o} !== 2'b01) begin n_bad++; $display("FAIL tie1 ready2: got %b want 01", {ic_data_ready_o, dc_data_ready_o}); end
            n_cmp++; if ({dc_addr_o, dc_data_o} !== {20'h00200, db}) begin n_bad++; $display("FAIL tie1 dc_resp: got %h want %h", {dc_addr_o, dc_data_o}, {20'h00200, db}); end
        end else begin
            n_cmp++; if ({ic_data_ready_o, dc_data_ready_o} !== 2'b10) begin n_bad++; $display("FAIL tie0 ready2: got %b want 10", {ic_data_ready_o, dc_data_ready_o}); end
            n_cmp++; if ({ic_addr_o, ic_data_o} !== {20'h00100, db}) begin n_bad++; $display("FAIL tie0 ic_resp: got %h want %h", {ic_addr_o, ic_data_o}, {20'h00100, db}); end
        end
        ic_rqst_i = 1'b0; dc_rqst_i = 1'b0;
        tick();
        tick();
        n_cmp++; if (arb_busy_o !== 1'b0) begin n_bad++; $display("FAIL tie%0d idle: got %b want 0", ic_first, arb_busy_o); end
    endtask

    task automatic test_dc_write();
        bit ok;
        logic [LW-1:0] wd = 128'hDEAD_0102_0304_0506_0708_090A_0B0C_BEEF;
        logic [LW-1:0] rd = {8{16'h5A5A}};
        dc_rqst_i = 1'b1; dc_write_i = 1'b1; dc_addr_i = 20'h12340; dc_data_i = wd;
        tick();
        dc_data_i = '1; dc_addr_i = 20'h0BEEF; dc_write_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if ({mem_rqst_o, mem_write_o, mem_addr_o} !== {2'b11, 20'h12340}) begin n_bad++; $display("FAIL dc_write ctl c%0d: got %h want %h", i, {mem_rqst_o, mem_write_o, mem_addr_o}, {2'b11, 20'h12340}); end
            n_cmp++; if (mem_data_o !== wd) begin n_bad++; $display("FAIL dc_write data c%0d: got %h want %h", i, mem_data_o, wd); end
            if (i < 2) tick();
        end
        mem_serve(0, rd, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL dc_write timeout: got %b want 1", ok); end
        n_cmp++; if ({ic_data_ready_o, dc_data_ready_o} !== 2'b01) begin n_bad++; $display("FAIL dc_write ready: got %b want 01", {ic_data_ready_o, dc_data_ready_o}); end
        n_cmp++; if ({dc_addr_o, dc_data_o} !== {20'h12340, rd}) begin n_bad++; $display("FAIL dc_write resp: got %h want %h", {dc_addr_o, dc_data_o}, {20'h12340, rd}); end
        dc_rqst_i = 1'b0;
        tick();
        n_cmp++; if ({dc_data_ready_o, mem_write_o, mem_rqst_o} !== 3'b000) begin n_bad++; $display("FAIL dc_write after: got %b want 000", {dc_data_ready_o, mem_write_o, mem_rqst_o}); end
        tick();
    endtask

    task automatic test_ignore_inputs();
        bit ok;
        logic [LW-1:0] di = {4{32'hC0DE_0001}};
        logic [LW-1:0] dd = {4{32'hC0DE_0002}};
        ic_rqst_i = 1'b1; ic_addr_i = 20'h00ABC;
        tick();
        dc_rqst_i = 1'b1; dc_write_i = 1'b0; dc_addr_i = 20'h00DDD;
        ic_addr_i = 20'h0FFFF;
        tick();
        n_cmp++; if (mem_addr_o !== 20'h00ABC) begin n_bad++; $display("FAIL ignore mem_addr: got %h want 00abc", mem_addr_o); end
        mem_serve(1, di, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL ignore timeout1: got %b want 1", ok); end
        n_cmp++; if ({ic_data_ready_o, dc_data_ready_o, ic_addr_o} !== {2'b10, 20'h00ABC}) begin n_bad++; $display("FAIL ignore ic_resp: got %h want %h", {ic_data_ready_o, dc_data_ready_o, ic_addr_o}, {2'b10, 20'h00ABC}); end
        ic_rqst_i = 1'b0;
        tick();
        n_cmp++; if (arb_busy_o !== 1'b0) begin n_bad++; $display("FAIL ignore idle: got %b want 0", arb_busy_o); end
        tick();
        n_cmp++; if ({mem_rqst_o, mem_addr_o} !== {1'b1, 20'h00DDD}) begin n_bad++; $display("FAIL ignore dc_grant: got %h want %h", {mem_rqst_o, mem_addr_o}, {1'b1, 20'h00DDD}); end
        mem_serve(2, dd, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL ignore timeout2: got %b want 1", ok); end
        n_cmp++; if ({dc_data_ready_o, dc_addr_o, dc_data_o} !== {1'b1, 20'h00DDD, dd}) begin n_bad++; $display("FAIL ignore dc_resp: got %h want %h", {dc_data_ready_o, dc_addr_o, dc_data_o}, {1'b1, 20'h00DDD, dd}); end
        dc_rqst_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [LW-1:0] dn = {2{64'h0123_4567_89AB_CDEF}};
        ic_rqst_i = 1'b1; ic_addr_i = 20'h00777;
        tick();
        n_cmp++; if (mem_rqst_o !== 1'b1) begin n_bad++; $display("FAIL rst_mid pre: got %b want 1", mem_rqst_o); end
        #2 rsn_i = 1'b0;
        #1;
        n_cmp++; if ({mem_rqst_o, arb_busy_o, mem_addr_o} !== '0) begin n_bad++; $display("FAIL rst_mid async: got %h want 0", {mem_rqst_o, arb_busy_o, mem_addr_o}); end
        n_cmp++; if ({ic_addr_o, ic_data_o, dc_addr_o} !== '0) begin n_bad++; $display("FAIL rst_mid outs: got %h want 0", {ic_addr_o, ic_data_o, dc_addr_o}); end
        ic_rqst_i = 1'b0;
        tick();
        rsn_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if ({ic_data_ready_o, dc_data_ready_o, arb_busy_o} !== 3'b000) begin n_bad++; $display("FAIL rst_mid no_pulse c%0d: got %b want 000", i, {ic_data_ready_o, dc_data_ready_o, arb_busy_o}); end
        end
        ic_rqst_i = 1'b1; ic_addr_i = 20'h00888;
        tick();
        n_cmp++; if (mem_addr_o !== 20'h00888) begin n_bad++; $display("FAIL rst_mid new_addr: got %h want 00888", mem_addr_o); end
        mem_serve(1, dn, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rst_mid timeout: got %b want 1", ok); end
        n_cmp++; if ({ic_data_ready_o, ic_addr_o, ic_data_o} !== {1'b1, 20'h00888, dn}) begin n_bad++; $display("FAIL rst_mid new_resp: got %h want %h", {ic_data_ready_o, ic_addr_o, ic_data_o}, {1'b1, 20'h00888, dn}); end
        last_ic_data = dn;
        ic_rqst_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_stray_ready();
        mem_data_ready_i = 1'b1; mem_data_i = {8{16'hFACE}};
        tick();
        mem_data_ready_i = 1'b0; mem_data_i = '0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if ({arb_busy_o, mem_rqst_o, ic_data_ready_o, dc_data_ready_o} !== 4'b0000) begin n_bad++; $display("FAIL stray ctl c%0d: got %b want 0000", i, {arb_busy_o, mem_rqst_o, ic_data_ready_o, dc_data_ready_o}); end
            tick();
        end
        n_cmp++; if (ic_data_o !== last_ic_data) begin n_bad++; $display("FAIL stray ic_data: got %h want %h", ic_data_o, last_ic_data); end
    endtask

    initial begin
        test_reset();
        test_ic_alone();
        test_tie(1'b0);
        test_reset();
        test_tie(1'b1);
        test_dc_write();
        test_ignore_inputs();
        test_reset_mid();
        test_stray_ready();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
